// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor computing a - b - bin_in over WIDTH cycles.
// One full_subtractor cell is reused for every bit, and the borrow is carried in a register.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, d_sh;
  logic             borrow_reg;
  logic             a_msb, b_msb;
  logic [CNT_W-1:0] cnt;
  logic             fs_d, fs_b;
  logic             accept, last;

  // Signed overflow from the operand signs and the result sign.
  function automatic logic ovf_calc(input logic am, input logic bm, input logic dm);
    return (am != bm) && (dm != am);
  endfunction

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow_reg),
    .d    (fs_d),
    .bout (fs_b)
  );

  always_comb begin
    accept    = start && ((state == IDLE) || (state == DONE));
    last      = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      d_sh       <= '0;
      borrow_reg <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == SHIFT);
      done  <= (state_nxt == DONE);
      if (accept) begin
        a_sh       <= a;
        b_sh       <= b;
        d_sh       <= '0;
        borrow_reg <= bin_in;
        a_msb      <= a[WIDTH-1];
        b_msb      <= b[WIDTH-1];
        cnt        <= '0;
      end else if (state == SHIFT) begin
        // One bit pair per edge; the difference enters at the MSB so the word lands LSB-aligned.
        a_sh       <= a_sh >> 1;
        b_sh       <= b_sh >> 1;
        d_sh       <= {fs_d, d_sh[WIDTH-1:1]};
        borrow_reg <= fs_b;
        cnt        <= cnt + 1'b1;
        if (last) begin
          diff       <= {fs_d, d_sh[WIDTH-1:1]};
          borrow_out <= fs_b;
          overflow   <= ovf_calc(a_msb, b_msb, fs_d);
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected results are queued at start and
// compared when done pulses.
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, start, bin_in;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, borrow_out, overflow;
  logic [WIDTH-1:0] diff;

  int tests = 0;
  int errors = 0;
  int done_cnt = 0;
  int busy_run = 0;
  logic [WIDTH+1:0] sb[$];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin_in(bin_in),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {overflow, borrow, diff} from plain integer arithmetic
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic bi);
    logic [WIDTH:0] full;
    int sx, sy, sr;
    logic ovf;
    full = {1'b0, x} - {1'b0, y} - (WIDTH+1)'(bi);
    sx = $signed(x);
    sy = $signed(y);
    sr = sx - sy - int'(bi);
    ovf = (sr > (1 << (WIDTH-1)) - 1) || (sr < -(1 << (WIDTH-1)));
    return {ovf, full[WIDTH], full[WIDTH-1:0]};
  endfunction

  // Output monitor: pops and compares on every done cycle
  always @(negedge clk) begin
    logic [WIDTH+1:0] exp;
    if (!rst) begin
      if (done) begin
        done_cnt++;
        check("busy_during_done", 32'(busy), 32'd0);
        check("busy_cycles", 32'(busy_run), 32'(WIDTH));
        busy_run = 0;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp = sb.pop_front();
          check("diff", 32'(diff), 32'(exp[WIDTH-1:0]));
          check("borrow_out", 32'(borrow_out), 32'(exp[WIDTH]));
          check("overflow", 32'(overflow), 32'(exp[WIDTH+1]));
        end
      end else if (busy) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
    end else begin
      busy_run = 0;
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic drive_start(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic bi);
    @(negedge clk);
    a = x; b = y; bin_in = bi; start = 1'b1;
  endtask

  task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic bi);
    int n;
    drive_start(x, y, bi);
    sb.push_back(model(x, y, bi));
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); bin_in = 1'($urandom);
    wait_done(n);
    check("latency", 32'(n), 32'(WIDTH));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_diff"}, 32'(diff), 32'd0);
    check({tag, "_borrow"}, 32'(borrow_out), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    int n, dc;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin_in = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    // Directed vectors
    do_op(8'h3C, 8'h15, 1'b0);
    do_op(8'h05, 8'h0A, 1'b0);
    do_op(8'h00, 8'h00, 1'b1);
    do_op(8'h80, 8'h01, 1'b0);
    do_op(8'h7F, 8'hFF, 1'b0);

    // Start during SHIFT is ignored and not queued
    drive_start(8'h10, 8'h01, 1'b0);
    sb.push_back(model(8'h10, 8'h01, 1'b0));
    dc = done_cnt;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(n);
    check("ignored_start_on_schedule", 32'(n), 32'(WIDTH - 3));
    repeat (12) @(negedge clk);
    check("single_done", 32'(done_cnt - dc), 32'd1);

    // Reset mid-SHIFT aborts the operation
    drive_start(8'h33, 8'h11, 1'b0);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    dc = done_cnt;
    @(negedge clk);
    check_zero_outputs("midreset");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_done_after_reset", 32'(done_cnt - dc), 32'd0);
    do_op(8'h09, 8'h04, 1'b0);

    // Start held high: back-to-back results every WIDTH+1 cycles
    drive_start(8'h20, 8'h01, 1'b0);
    sb.push_back(model(8'h20, 8'h01, 1'b0));
    for (int k = 0; k < 4; k++) begin
      wait_done(n);
      if (k > 0) check("b2b_period", 32'(n), 32'(WIDTH + 1));
      if (k < 3) sb.push_back(model(8'h20, 8'h01, 1'b0));
      else start = 1'b0;
    end
    repeat (12) @(negedge clk);

    // Random operands
    for (int i = 0; i < 1000; i++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
